// File: rtl/mem_access_unit_if.sv
// Data-side SRAM-like bus between the MEM-stage load/store unit and the bus bridge.
// The unit is the master: it issues one request and then waits for its response.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [LANES-1:0]  data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage load/store controller: alignment check, bus request/response
// sequencing with pipeline stall, flush-safe discard, and load lane extraction.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [7:0]          op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [31:0]         wdata_i,
  input  logic                flush_i,
  input  logic                hold_i,
  output logic                stall_o,
  output logic [31:0]         rdata_o,
  output logic                rdata_valid_o,
  output logic                adel_o,
  output logic                ades_o,
  output logic [ADDR_W-1:0]   bad_addr_o,
  mem_access_unit_if.master   bus
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DISCARD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic              signExt_q;
  logic              isLoad_q;
  logic [LANES-1:0]  wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       rdata_q;

  logic              isLoad, isStore, isMem, signExt, misaligned;
  logic [1:0]        sizeDec;
  logic              addrErr, accept, capture;
  logic [OFF_W-1:0]  off;
  logic [LANES-1:0]  strbBase, strbNext;
  logic [DATA_W-1:0] wdataNext;
  logic [OFF_W+2:0]  shiftAmt;
  logic [DATA_W-1:0] laneData;
  logic [31:0]       loadExt;

  always_comb begin
    isLoad  = 1'b0;
    isStore = 1'b0;
    sizeDec = 2'd0;
    signExt = 1'b0;
    case (op_i)
      EXE_LB_OP:  begin isLoad  = 1'b1; sizeDec = 2'd0; signExt = 1'b1; end
      EXE_LBU_OP: begin isLoad  = 1'b1; sizeDec = 2'd0; end
      EXE_LH_OP:  begin isLoad  = 1'b1; sizeDec = 2'd1; signExt = 1'b1; end
      EXE_LHU_OP: begin isLoad  = 1'b1; sizeDec = 2'd1; end
      EXE_LW_OP:  begin isLoad  = 1'b1; sizeDec = 2'd2; end
      EXE_SB_OP:  begin isStore = 1'b1; sizeDec = 2'd0; end
      EXE_SH_OP:  begin isStore = 1'b1; sizeDec = 2'd1; end
      EXE_SW_OP:  begin isStore = 1'b1; sizeDec = 2'd2; end
      default:    ;
    endcase
  end

  assign isMem      = isLoad | isStore;
  assign misaligned = ((sizeDec == 2'd1) && addr_i[0]) ||
                      ((sizeDec == 2'd2) && (addr_i[1:0] != 2'b00));
  assign addrErr    = valid_i && isMem && misaligned && (state_q == IDLE);
  assign accept     = valid_i && isMem && !misaligned && !flush_i && (state_q == IDLE);
  assign off        = addr_i[OFF_W-1:0];

  assign adel_o     = addrErr && isLoad;
  assign ades_o     = addrErr && isStore;
  assign bad_addr_o = addrErr ? addr_i : '0;

  // Store lanes: strobe mask shifted to the byte offset, data replicated across the bus
  always_comb begin
    strbBase  = '0;
    wdataNext = '0;
    case (sizeDec)
      2'd0: begin
        strbBase  = LANES'(4'h1);
        wdataNext = {LANES{wdata_i[7:0]}};
      end
      2'd1: begin
        strbBase  = LANES'(4'h3);
        wdataNext = {(LANES/2){wdata_i[15:0]}};
      end
      default: begin
        strbBase  = LANES'(4'hF);
        wdataNext = {(DATA_W/32){wdata_i}};
      end
    endcase
    strbNext = isStore ? (strbBase << off) : '0;
  end

  assign shiftAmt = {addr_q[OFF_W-1:0], 3'b000};
  assign laneData = bus.data_rdata >> shiftAmt;

  always_comb begin
    loadExt = laneData[31:0];
    case (size_q)
      2'd0:    loadExt = {{24{signExt_q & laneData[7]}}, laneData[7:0]};
      2'd1:    loadExt = {{16{signExt_q & laneData[15]}}, laneData[15:0]};
      default: loadExt = laneData[31:0];
    endcase
  end

  assign capture = !flush_i && bus.data_data_ok &&
                   ((state_q == WAIT) || ((state_q == REQ) && bus.data_addr_ok));

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          stall_o = 1'b1;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus.data_addr_ok) begin
          if (flush_i) state_d = bus.data_data_ok ? IDLE : DISCARD;
          else         state_d = bus.data_data_ok ? DONE : WAIT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (flush_i)                state_d = bus.data_data_ok ? IDLE : DISCARD;
        else if (bus.data_data_ok)  state_d = DONE;
      end
      DONE: begin
        if (flush_i || !hold_i) state_d = IDLE;
      end
      DISCARD: begin
        // The orphaned response must drain before a new request may go out
        stall_o = valid_i && isMem;
        if (bus.data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= 2'd0;
      wr_q      <= 1'b0;
      signExt_q <= 1'b0;
      isLoad_q  <= 1'b0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q    <= addr_i;
        size_q    <= sizeDec;
        wr_q      <= isStore;
        signExt_q <= signExt;
        isLoad_q  <= isLoad;
        wstrb_q   <= strbNext;
        wdata_q   <= isStore ? wdataNext : '0;
      end
      if (capture && isLoad_q) rdata_q <= loadExt;
    end
  end

  assign bus.data_req   = (state_q == REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wstrb = wstrb_q;
  assign bus.data_wdata = wdata_q;

  assign rdata_o        = rdata_q;
  assign rdata_valid_o  = (state_q == DONE) && isLoad_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit and a 64-bit instance driven in turn
// through load/store, misalignment, flush, hold and reset scenarios.
module tb_mem_access_unit;

  localparam logic [7:0] LB  = 8'hE0;
  localparam logic [7:0] LH  = 8'hE1;
  localparam logic [7:0] LW  = 8'hE3;
  localparam logic [7:0] LBU = 8'hE4;
  localparam logic [7:0] SH  = 8'hE9;
  localparam logic [7:0] SW  = 8'hEB;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  logic        v32, fl32, h32, st32, rv32, adel32, ades32;
  logic [7:0]  op32;
  logic [31:0] a32, wd32, rd32, bad32;

  logic        v64, fl64, h64, st64, rv64, adel64, ades64;
  logic [7:0]  op64;
  logic [31:0] a64, wd64, rd64, bad64;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .valid_i(v32), .op_i(op32), .addr_i(a32), .wdata_i(wd32),
    .flush_i(fl32), .hold_i(h32), .stall_o(st32), .rdata_o(rd32), .rdata_valid_o(rv32),
    .adel_o(adel32), .ades_o(ades32), .bad_addr_o(bad32), .bus(bus32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .valid_i(v64), .op_i(op64), .addr_i(a64), .wdata_i(wd64),
    .flush_i(fl64), .hold_i(h64), .stall_o(st64), .rdata_o(rd64), .rdata_valid_o(rv64),
    .adel_o(adel64), .ades_o(ades64), .bad_addr_o(bad64), .bus(bus64)
  );

  // Drives one cycle of inputs after the falling edge, then settles before checks
  task automatic applyStimulus32(input logic v, input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, input logic fl, input logic h,
                                 input logic aok, input logic dok, input logic [31:0] rdat);
    @(negedge clk);
    v32 = v; op32 = op; a32 = a; wd32 = wd; fl32 = fl; h32 = h;
    bus32.data_addr_ok = aok; bus32.data_data_ok = dok; bus32.data_rdata = rdat;
    #1;
  endtask

  task automatic applyStimulus64(input logic v, input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, input logic fl, input logic h,
                                 input logic aok, input logic dok, input logic [63:0] rdat);
    @(negedge clk);
    v64 = v; op64 = op; a64 = a; wd64 = wd; fl64 = fl; h64 = h;
    bus64.data_addr_ok = aok; bus64.data_data_ok = dok; bus64.data_rdata = rdat;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    v32 = 0; op32 = 0; a32 = 0; wd32 = 0; fl32 = 0; h32 = 0;
    v64 = 0; op64 = 0; a64 = 0; wd64 = 0; fl64 = 0; h64 = 0;
    bus32.data_addr_ok = 0; bus32.data_data_ok = 0; bus32.data_rdata = '0;
    bus64.data_addr_ok = 0; bus64.data_data_ok = 0; bus64.data_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst32_req",   bus32.data_req, 0);
    checkOutput("rst32_stall", st32, 0);
    checkOutput("rst32_rdata", rd32, 0);
    checkOutput("rst32_rv",    rv32, 0);
    checkOutput("rst32_addr",  bus32.data_addr, 0);
    checkOutput("rst32_size",  bus32.data_size, 0);
    checkOutput("rst64_wstrb", bus64.data_wstrb, 0);
    checkOutput("rst64_wdata", bus64.data_wdata, 0);
    checkOutput("rst64_wr",    bus64.data_wr, 0);
    checkOutput("rst64_bad",   bad64, 0);

    $display("[TB] LW 0x100 on 32-bit bus");
    applyStimulus32(1, LW, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("lw_t0_stall", st32, 1);
    checkOutput("lw_t0_req",   bus32.data_req, 0);
    applyStimulus32(1, LW, 32'h100, 0, 0, 0, 1, 0, 0);
    checkOutput("lw_t1_req",   bus32.data_req, 1);
    checkOutput("lw_t1_addr",  bus32.data_addr, 32'h100);
    checkOutput("lw_t1_size",  bus32.data_size, 2);
    checkOutput("lw_t1_wr",    bus32.data_wr, 0);
    checkOutput("lw_t1_stall", st32, 1);
    applyStimulus32(1, LW, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("lw_t2_req",   bus32.data_req, 0);
    checkOutput("lw_t2_stall", st32, 1);
    applyStimulus32(1, LW, 32'h100, 0, 0, 0, 0, 1, 32'h8899AABB);
    checkOutput("lw_t3_stall", st32, 1);
    checkOutput("lw_t3_rv",    rv32, 0);
    applyStimulus32(1, LW, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("lw_t4_rv",    rv32, 1);
    checkOutput("lw_t4_rdata", rd32, 32'h8899AABB);
    checkOutput("lw_t4_stall", st32, 0);

    $display("[TB] LH 0x202 with hold in DONE");
    applyStimulus32(1, LH, 32'h202, 0, 0, 0, 0, 0, 0);
    checkOutput("lh_t0_stall", st32, 1);
    applyStimulus32(1, LH, 32'h202, 0, 0, 0, 1, 1, 32'h80010000);
    checkOutput("lh_t1_req",   bus32.data_req, 1);
    checkOutput("lh_t1_size",  bus32.data_size, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus32(1, LH, 32'h202, 0, 0, 1, 0, 0, 32'h12345678);
      checkOutput("lh_hold_rv",    rv32, 1);
      checkOutput("lh_hold_rdata", rd32, 32'hFFFF8001);
      checkOutput("lh_hold_stall", st32, 0);
      checkOutput("lh_hold_req",   bus32.data_req, 0);
    end
    applyStimulus32(1, LH, 32'h202, 0, 0, 0, 0, 0, 0);
    checkOutput("lh_release_rv", rv32, 1);
    applyStimulus32(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lh_idle_rv",    rv32, 0);
    checkOutput("lh_idle_rdata", rd32, 32'hFFFF8001);

    $display("[TB] misaligned accesses");
    applyStimulus32(1, LW, 32'h102, 0, 0, 0, 0, 0, 0);
    checkOutput("mis_lw_adel",  adel32, 1);
    checkOutput("mis_lw_ades",  ades32, 0);
    checkOutput("mis_lw_bad",   bad32, 32'h102);
    checkOutput("mis_lw_stall", st32, 0);
    applyStimulus32(1, LW, 32'h102, 0, 0, 0, 0, 0, 0);
    checkOutput("mis_lw_req",   bus32.data_req, 0);
    applyStimulus32(1, SH, 32'h1, 32'hBEEF, 0, 0, 0, 0, 0);
    checkOutput("mis_sh_ades",  ades32, 1);
    checkOutput("mis_sh_adel",  adel32, 0);
    checkOutput("mis_sh_bad",   bad32, 32'h1);
    applyStimulus32(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mis_clr_ades", ades32, 0);
    checkOutput("mis_clr_req",  bus32.data_req, 0);

    $display("[TB] flush in WAIT then pending LW");
    applyStimulus32(1, LW, 32'h300, 0, 0, 0, 0, 0, 0);
    applyStimulus32(1, LW, 32'h300, 0, 0, 0, 1, 0, 0);
    applyStimulus32(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("fl_wait_stall", st32, 1);
    applyStimulus32(1, LW, 32'h400, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_disc_stall", st32, 1);
    checkOutput("fl_disc_req",   bus32.data_req, 0);
    applyStimulus32(1, LW, 32'h400, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    checkOutput("fl_drop_stall", st32, 1);
    checkOutput("fl_drop_req",   bus32.data_req, 0);
    checkOutput("fl_drop_rv",    rv32, 0);
    applyStimulus32(1, LW, 32'h400, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_acc_req",    bus32.data_req, 0);
    checkOutput("fl_acc_rv",     rv32, 0);
    checkOutput("fl_acc_rdata",  rd32, 32'hFFFF8001);
    applyStimulus32(1, LW, 32'h400, 0, 0, 0, 1, 1, 32'h11223344);
    checkOutput("fl_new_req",    bus32.data_req, 1);
    checkOutput("fl_new_addr",   bus32.data_addr, 32'h400);
    applyStimulus32(1, LW, 32'h400, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_new_rdata",  rd32, 32'h11223344);
    checkOutput("fl_new_rv",     rv32, 1);
    applyStimulus32(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset asserted in WAIT");
    applyStimulus32(1, LW, 32'h500, 0, 0, 0, 0, 0, 0);
    applyStimulus32(1, LW, 32'h500, 0, 0, 0, 1, 0, 0);
    checkOutput("rw_addr", bus32.data_addr, 32'h500);
    applyStimulus32(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus32(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
    rst = 1'b0;
    checkOutput("rw_req",   bus32.data_req, 0);
    checkOutput("rw_addr0", bus32.data_addr, 0);
    checkOutput("rw_rdata", rd32, 0);
    checkOutput("rw_rv",    rv32, 0);
    checkOutput("rw_stall", st32, 0);
    applyStimulus32(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rw_stray_rv",    rv32, 0);
    checkOutput("rw_stray_rdata", rd32, 0);
    checkOutput("rw_stray_req",   bus32.data_req, 0);

    $display("[TB] LB / LBU lane 5 on 64-bit bus");
    applyStimulus64(1, LB, 32'h1005, 0, 0, 0, 0, 0, 0);
    checkOutput("lb_t0_stall", st64, 1);
    applyStimulus64(1, LB, 32'h1005, 0, 0, 0, 1, 1, 64'h0000F000_00000000);
    checkOutput("lb_t1_req",   bus64.data_req, 1);
    checkOutput("lb_t1_size",  bus64.data_size, 0);
    checkOutput("lb_t1_wstrb", bus64.data_wstrb, 0);
    applyStimulus64(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lb_rdata",    rd64, 32'hFFFFFFF0);
    checkOutput("lb_rv",       rv64, 1);
    applyStimulus64(1, LBU, 32'h1005, 0, 0, 0, 0, 0, 0);
    applyStimulus64(1, LBU, 32'h1005, 0, 0, 0, 1, 1, 64'h0000F000_00000000);
    applyStimulus64(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lbu_rdata",   rd64, 32'h000000F0);
    checkOutput("lbu_rv",      rv64, 1);

    $display("[TB] SH / SW store lanes on 64-bit bus");
    applyStimulus64(1, SH, 32'h2006, 32'h0000BEEF, 0, 0, 0, 0, 0);
    checkOutput("sh_t0_stall", st64, 1);
    applyStimulus64(1, SH, 32'h2006, 32'h0000BEEF, 0, 0, 1, 0, 0);
    checkOutput("sh_wstrb", bus64.data_wstrb, 8'hC0);
    checkOutput("sh_wdata", bus64.data_wdata, 64'hBEEFBEEF_BEEFBEEF);
    checkOutput("sh_size",  bus64.data_size, 1);
    checkOutput("sh_wr",    bus64.data_wr, 1);
    checkOutput("sh_addr",  bus64.data_addr, 32'h2006);
    applyStimulus64(1, SH, 32'h2006, 32'h0000BEEF, 0, 0, 0, 1, 0);
    checkOutput("sh_wait_stall", st64, 1);
    checkOutput("sh_wait_req",   bus64.data_req, 0);
    applyStimulus64(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sh_done_rv",    rv64, 0);
    checkOutput("sh_done_stall", st64, 0);
    applyStimulus64(1, SW, 32'h3004, 32'h12345678, 0, 0, 0, 0, 0);
    applyStimulus64(1, SW, 32'h3004, 32'h12345678, 0, 0, 1, 1, 0);
    checkOutput("sw_wstrb", bus64.data_wstrb, 8'hF0);
    checkOutput("sw_wdata", bus64.data_wdata, 64'h12345678_12345678);
    checkOutput("sw_size",  bus64.data_size, 2);
    applyStimulus64(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sw_done_stall", st64, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
